// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle between the control unit and the multi-cycle ALU.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               go;
    logic [5:0]         funct;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   out;
    logic               ovf;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               done;

    modport master (output go, funct, shamt, a, b, input out, ovf, hi, lo, busy, done);
    modport slave  (input go, funct, shamt, a, b, output out, ovf, hi, lo, busy, done);
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle MIPS R-type ALU: single-cycle ops complete at the go edge,
// mult/div run as shift-add / restoring-division sequencers writing HI/LO.
module alu_mc #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     bm;
    logic                 neg_q;
    logic                 neg_r;
    logic                 op_div;

    logic [WIDTH-1:0]     sum, dif, sc_res;
    logic                 sc_wr, sc_ovf, sc_hi_wr, sc_lo_wr;
    logic [SHAMT_W-1:0]   vamt;

    assign sum  = bus.a + bus.b;
    assign dif  = bus.a - bus.b;
    assign vamt = bus.b[SHAMT_W-1:0];

    // Single-cycle result and write enables
    always_comb begin
        sc_res   = '0;
        sc_wr    = 1'b1;
        sc_ovf   = 1'b0;
        sc_hi_wr = 1'b0;
        sc_lo_wr = 1'b0;
        case (bus.funct)
            F_SLL:  sc_res = bus.a << bus.shamt;
            F_SRL:  sc_res = bus.a >> bus.shamt;
            F_SRA:  sc_res = WIDTH'($signed(bus.a) >>> bus.shamt);
            F_SLLV: sc_res = bus.a << vamt;
            F_SRLV: sc_res = bus.a >> vamt;
            F_SRAV: sc_res = WIDTH'($signed(bus.a) >>> vamt);
            F_MFHI: sc_res = bus.hi;
            F_MFLO: sc_res = bus.lo;
            F_MTHI: begin sc_wr = 1'b0; sc_hi_wr = 1'b1; end
            F_MTLO: begin sc_wr = 1'b0; sc_lo_wr = 1'b1; end
            F_ADD: begin
                sc_res = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            F_ADDU: sc_res = sum;
            F_SUB: begin
                sc_res = dif;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            F_SUBU: sc_res = dif;
            F_AND:  sc_res = bus.a & bus.b;
            F_OR:   sc_res = bus.a | bus.b;
            F_XOR:  sc_res = bus.a ^ bus.b;
            F_NOR:  sc_res = ~(bus.a | bus.b);
            F_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            F_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: sc_res = '0;
        endcase
    end

    // Operand magnitudes and sign bookkeeping for mult/div setup
    logic             is_mult, is_div, sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mult = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
    assign is_div  = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
    assign sgn     = ~bus.funct[0];
    assign a_neg   = sgn & bus.a[WIDTH-1];
    assign b_neg   = sgn & bus.b[WIDTH-1];
    assign a_mag   = a_neg ? -bus.a : bus.a;
    assign b_mag   = b_neg ? -bus.b : bus.b;

    // acc holds {partial product, remaining multiplier} or {remainder, quotient}
    logic [WIDTH:0]       mul_sum, r_sh, r_dif;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     fix_quo, fix_rem;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bm};
    assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    assign r_sh     = acc[2*WIDTH-1:WIDTH-1];
    assign r_dif    = r_sh - {1'b0, bm};
    assign div_next = r_dif[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {r_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign prod     = neg_q ? -acc : acc;
    assign fix_quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign fix_rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            bm       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_div   <= 1'b0;
            bus.out  <= '0;
            bus.ovf  <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        if (is_mult || is_div) begin
                            bus.busy <= 1'b1;
                            op_div   <= is_div;
                            bm       <= b_mag;
                            cnt      <= CNT_W'(WIDTH);
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            acc      <= {{WIDTH{1'b0}}, a_mag};
                            if (is_div && bus.b == '0) begin
                                // Divide by zero: FIX writes hi=a, lo=all-ones unsigned
                                acc   <= {bus.a, {WIDTH{1'b1}}};
                                neg_q <= 1'b0;
                                neg_r <= 1'b0;
                                state <= FIX;
                            end else begin
                                state <= is_div ? DIV : MUL;
                            end
                        end else begin
                            bus.done <= 1'b1;
                            if (sc_wr) begin
                                bus.out <= sc_res;
                                bus.ovf <= sc_ovf;
                            end
                            if (sc_hi_wr) bus.hi <= bus.a;
                            if (sc_lo_wr) bus.lo <= bus.a;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= (state == DIV) ? div_next : mul_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    if (op_div) begin
                        bus.hi <= fix_rem;
                        bus.lo <= fix_quo;
                    end else begin
                        bus.hi <= prod[2*WIDTH-1:WIDTH];
                        bus.lo <= prod[WIDTH-1:0];
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    cnt      <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: scoreboard of expected {out,hi,lo,ovf} popped on every done pulse,
// plus per-scenario checks of latency, handshake and directed results.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus ();
    alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] out;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_out, m_hi, m_lo;
    logic        m_ovf;

    // Scoreboard monitor: every done pulse must match the oldest pending expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.done === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done out=%h hi=%h lo=%h", bus.out, bus.hi, bus.lo);
            end else begin
                mon_e = sbq.pop_front();
                if ({bus.out, bus.hi, bus.lo, bus.ovf} !== {mon_e.out, mon_e.hi, mon_e.lo, mon_e.ovf}) begin
                    errors++;
                    $display("FAIL scoreboard got out=%h hi=%h lo=%h ovf=%b exp out=%h hi=%h lo=%h ovf=%b",
                             bus.out, bus.hi, bus.lo, bus.ovf, mon_e.out, mon_e.hi, mon_e.lo, mon_e.ovf);
                end
            end
        end
    end

    task automatic model(input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
        longint      sq, sr;
        logic [63:0] p;
        lat = 1;
        case (f)
            6'h00: begin m_out = a << sh; m_ovf = 1'b0; end
            6'h02: begin m_out = a >> sh; m_ovf = 1'b0; end
            6'h03: begin m_out = 32'($signed(a) >>> sh); m_ovf = 1'b0; end
            6'h04: begin m_out = a << b[4:0]; m_ovf = 1'b0; end
            6'h06: begin m_out = a >> b[4:0]; m_ovf = 1'b0; end
            6'h07: begin m_out = 32'($signed(a) >>> b[4:0]); m_ovf = 1'b0; end
            6'h10: begin m_out = m_hi; m_ovf = 1'b0; end
            6'h12: begin m_out = m_lo; m_ovf = 1'b0; end
            6'h11: m_hi = a;
            6'h13: m_lo = a;
            6'h20, 6'h21: begin
                sq = longint'($signed(a)) + longint'($signed(b));
                m_out = a + b;
                m_ovf = (f == 6'h20) && (sq > 64'sd2147483647 || sq < -64'sd2147483648);
            end
            6'h22, 6'h23: begin
                sq = longint'($signed(a)) - longint'($signed(b));
                m_out = a - b;
                m_ovf = (f == 6'h22) && (sq > 64'sd2147483647 || sq < -64'sd2147483648);
            end
            6'h24: begin m_out = a & b; m_ovf = 1'b0; end
            6'h25: begin m_out = a | b; m_ovf = 1'b0; end
            6'h26: begin m_out = a ^ b; m_ovf = 1'b0; end
            6'h27: begin m_out = ~(a | b); m_ovf = 1'b0; end
            6'h2A: begin m_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; m_ovf = 1'b0; end
            6'h2B: begin m_out = (a < b) ? 32'd1 : 32'd0; m_ovf = 1'b0; end
            6'h18: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32]; m_lo = p[31:0]; lat = 34;
            end
            6'h19: begin
                p = 64'(a) * 64'(b);
                m_hi = p[63:32]; m_lo = p[31:0]; lat = 34;
            end
            6'h1A, 6'h1B: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; lat = 2;
                end else begin
                    if (f == 6'h1A) begin
                        sq = longint'($signed(a)) / longint'($signed(b));
                        sr = longint'($signed(a)) % longint'($signed(b));
                    end else begin
                        sq = longint'(a) / longint'(b);
                        sr = longint'(a) % longint'(b);
                    end
                    m_lo = sq[31:0]; m_hi = sr[31:0]; lat = 34;
                end
            end
            default: begin m_out = 32'd0; m_ovf = 1'b0; end
        endcase
        sbq.push_back('{m_out, m_hi, m_lo, m_ovf});
    endtask

    // Drives one op starting #1 after an edge; returns the done latency in cycles.
    task automatic issue(input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
        int exp_lat;
        model(f, sh, a, b, exp_lat);
        bus.go = 1'b1; bus.funct = f; bus.shamt = sh; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.go = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL timeout funct=%h no done after %0d cycles", f, lat);
        end
    endtask

    task automatic test_reset();
        bus.go = 1'b0; bus.funct = '0; bus.shamt = '0; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out, bus.hi, bus.lo, bus.ovf, bus.busy, bus.done} !== {96'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state out=%h hi=%h lo=%h ovf=%b busy=%b done=%b exp all zero",
                     bus.out, bus.hi, bus.lo, bus.ovf, bus.busy, bus.done);
        end
        m_out = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        issue(6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1, lat);
        checks++;
        if (lat !== 1 || bus.out !== 32'h8000_0000 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf lat=%0d out=%h ovf=%b exp lat=1 out=80000000 ovf=1", lat, bus.out, bus.ovf);
        end
        issue(6'h21, 5'd0, 32'h7FFF_FFFF, 32'd1, lat);
        checks++;
        if (bus.out !== 32'h8000_0000 || bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL addu out=%h ovf=%b busy=%b exp out=80000000 ovf=0 busy=0", bus.out, bus.ovf, bus.busy);
        end
        issue(6'h22, 5'd0, 32'h8000_0000, 32'd1, lat);
        checks++;
        if (bus.out !== 32'h7FFF_FFFF || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf out=%h ovf=%b exp out=7fffffff ovf=1", bus.out, bus.ovf);
        end
    endtask

    task automatic test_shift_cmp();
        int lat;
        issue(6'h03, 5'd4, 32'h8000_0000, 32'd0, lat);
        checks++;
        if (bus.out !== 32'hF800_0000) begin
            errors++; $display("FAIL sra out=%h exp f8000000", bus.out);
        end
        issue(6'h06, 5'd0, 32'h8000_0000, 32'h24, lat);
        checks++;
        if (bus.out !== 32'h0800_0000) begin
            errors++; $display("FAIL srlv out=%h exp 08000000", bus.out);
        end
        issue(6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, lat);
        checks++;
        if (bus.out !== 32'd1) begin
            errors++; $display("FAIL slt out=%h exp 1", bus.out);
        end
        issue(6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1, lat);
        checks++;
        if (bus.out !== 32'd0) begin
            errors++; $display("FAIL sltu out=%h exp 0", bus.out);
        end
        issue(6'h3F, 5'd0, 32'h1234, 32'h5678, lat);
        checks++;
        if (bus.out !== 32'd0 || lat !== 1) begin
            errors++; $display("FAIL unlisted out=%h lat=%0d exp out=0 lat=1", bus.out, lat);
        end
    endtask

    task automatic test_muldiv();
        int lat;
        issue(6'h18, 5'd0, 32'hFFFF_FFFD, 32'd5, lat);
        checks++;
        if (lat !== 34 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult lat=%0d hi=%h lo=%h exp lat=34 hi=ffffffff lo=fffffff1", lat, bus.hi, bus.lo);
        end
        issue(6'h19, 5'd0, 32'hFFFF_FFFF, 32'd2, lat);
        checks++;
        if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL multu hi=%h lo=%h exp hi=1 lo=fffffffe", bus.hi, bus.lo);
        end
        issue(6'h10, 5'd0, 32'd0, 32'd0, lat);
        checks++;
        if (bus.out !== 32'd1) begin
            errors++; $display("FAIL mfhi out=%h exp 1", bus.out);
        end
        issue(6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2, lat);
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div hi=%h lo=%h exp hi=ffffffff lo=fffffffd", bus.hi, bus.lo);
        end
        issue(6'h1B, 5'd0, 32'd7, 32'd0, lat);
        checks++;
        if (lat !== 2 || bus.hi !== 32'd7 || bus.lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div0 lat=%0d hi=%h lo=%h exp lat=2 hi=7 lo=ffffffff", lat, bus.hi, bus.lo);
        end
        issue(6'h1A, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
            errors++; $display("FAIL div_min hi=%h lo=%h exp hi=0 lo=80000000", bus.hi, bus.lo);
        end
        issue(6'h11, 5'd0, 32'hA5A5_0001, 32'd0, lat);
        issue(6'h13, 5'd0, 32'h0000_5A5A, 32'd0, lat);
        issue(6'h12, 5'd0, 32'd0, 32'd0, lat);
        checks++;
        if (bus.out !== 32'h0000_5A5A || bus.hi !== 32'hA5A5_0001) begin
            errors++; $display("FAIL mthi_mtlo out=%h hi=%h exp out=00005a5a hi=a5a50001", bus.out, bus.hi);
        end
    endtask

    task automatic test_random();
        logic [5:0] fl [0:13];
        int         lat;
        logic [5:0] f;
        logic [31:0] a, b;
        fl = '{6'h00, 6'h07, 6'h20, 6'h22, 6'h25, 6'h27, 6'h2A, 6'h2B,
               6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
        for (int i = 0; i < 24; i++) begin
            f = fl[$urandom_range(13)];
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(15)) : $urandom;
            issue(f, 5'($urandom_range(31)), a, b, lat);
        end
    endtask

    task automatic test_ignore_go();
        int          lat, ndone, nbusy;
        logic [31:0] out_before;
        out_before = bus.out;
        model(6'h19, 5'd0, 32'h0001_0000, 32'h0001_0000, lat);
        bus.go = 1'b1; bus.funct = 6'h19; bus.a = 32'h0001_0000; bus.b = 32'h0001_0000;
        @(posedge clk); #1;
        ndone = 0; nbusy = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) ndone++;
            if (bus.busy === 1'b1) begin
                bus.go = 1'b1; bus.funct = 6'h20; bus.a = $urandom; bus.b = $urandom;
            end else begin
                bus.go = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.go = 1'b0;
        checks++;
        if (ndone !== 1 || nbusy !== 33 || bus.out !== out_before || bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL ignore_go dones=%0d busy_cycles=%0d out=%h hi=%h lo=%h exp 1 33 out=%h hi=1 lo=0",
                     ndone, nbusy, bus.out, bus.hi, bus.lo, out_before);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        issue(6'h21, 5'd0, 32'd1, 32'd2, lat1);
        issue(6'h23, 5'd0, 32'd10, 32'd3, lat2);
        checks++;
        if (lat1 !== 1 || lat2 !== 1 || bus.out !== 32'd7) begin
            errors++;
            $display("FAIL back_to_back lat=%0d,%0d out=%h exp lat=1,1 out=7", lat1, lat2, bus.out);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        issue(6'h11, 5'd0, 32'h55, 32'd0, lat);
        bus.go = 1'b1; bus.funct = 6'h1A; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7;
        @(posedge clk);
        #1 bus.go = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_midop busy=%b done=%b hi=%h lo=%h exp all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        sbq.delete();
        m_out = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(6'h1B, 5'd0, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 34 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++;
            $display("FAIL divu_after_reset lat=%0d hi=%h lo=%h exp lat=34 hi=2 lo=e", lat, bus.hi, bus.lo);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift_cmp();
        test_muldiv();
        test_back_to_back();
        test_random();
        test_ignore_go();
        test_reset_midop();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL pending_expectations left=%0d exp 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
